// File: rtl/led_pkg.sv
// Shared types and constants for the LED decoder block.
// Contents: display-mode enum, LED "all dark" constant for active-low banks.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // Widest LED bank supported; users truncate with OUT_W'(LED_ALL_OFF).
    localparam int unsigned LED_MAX_W = 256;

    // Active-low LEDs: all ones means every LED is dark.
    localparam logic [LED_MAX_W-1:0] LED_ALL_OFF = '1;

endpackage : led_pkg

// File: rtl/tick_prescaler.sv
// Display tick prescaler: counts TICK_DIV clock cycles per tick.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear; forces count to 0 and suppresses tick
//   en    - count enable
//   tick  - combinational pulse on the edge where the counter wraps
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count and wrap detect; clear wins over a pending wrap
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule : tick_prescaler

// File: rtl/led_decoder_seq.sv
// N-to-2^N one-hot LED decoder with enable match and timed display modes
// (static, chase, blink, off). LED outputs are registered and active-low.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   enable - block active only when equal to EN_MATCH
//   switch - selected LED index
//   mode   - 0 static, 1 chase, 2 blink, 3 off
//   dir    - chase direction: 0 up, 1 down
//   led    - registered active-low LED bank (0 = lit)
//   tick_o - registered one-cycle pulse aligned with tick-driven updates
module led_decoder_seq
    import led_pkg::*;
#(
    parameter int unsigned          SEL_W    = 3,
    parameter int unsigned          EN_W     = 3,
    parameter logic [EN_W-1:0]      EN_MATCH = EN_W'(3'b100),
    parameter int unsigned          TICK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [EN_W-1:0]         enable,
    input  logic [SEL_W-1:0]        switch,
    input  logic [1:0]              mode,
    input  logic                    dir,
    output logic [(2**SEL_W)-1:0]   led,
    output logic                    tick_o
);

    localparam int unsigned OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] LEDS_OFF = OUT_W'(LED_ALL_OFF);

    // Active-low one-hot for a single lit LED
    function automatic logic [OUT_W-1:0] led_on(input logic [SEL_W-1:0] idx);
        return ~(OUT_W'(1) << idx);
    endfunction

    mode_e              mode_in;
    mode_e              mode_q;
    logic [SEL_W-1:0]   pos_q,   pos_d;
    logic               phase_q, phase_d;
    logic [OUT_W-1:0]   led_q,   led_d;
    logic               tick_q,  tick_d;
    logic               en_ok;
    logic               mode_chg;
    logic               tick;

    assign mode_in  = mode_e'(mode);
    assign en_ok    = (enable == EN_MATCH);
    assign mode_chg = (mode_in != mode_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en_ok || mode_chg),
        .en    (en_ok),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_STATIC;
            pos_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= LEDS_OFF;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    // Next state: disable beats mode entry, which beats a tick
    always_comb begin
        pos_d   = pos_q;
        phase_d = phase_q;
        led_d   = led_q;
        tick_d  = 1'b0;
        if (!en_ok) begin
            phase_d = 1'b0;
            led_d   = LEDS_OFF;
        end else if (mode_chg) begin
            // Entry: every lit mode starts by showing the switch index
            pos_d   = switch;
            phase_d = 1'b0;
            led_d   = (mode_in == MODE_OFF) ? LEDS_OFF : led_on(switch);
        end else begin
            tick_d = tick;
            unique case (mode_q)
                MODE_STATIC: begin
                    led_d = led_on(switch);
                end
                MODE_CHASE: begin
                    // Wrap comes for free from SEL_W-bit modulo arithmetic
                    if (tick) begin
                        pos_d = dir ? (pos_q - SEL_W'(1)) : (pos_q + SEL_W'(1));
                    end
                    led_d = led_on(pos_d);
                end
                MODE_BLINK: begin
                    if (tick) begin
                        phase_d = !phase_q;
                    end
                    led_d = phase_d ? LEDS_OFF : led_on(switch);
                end
                MODE_OFF: begin
                    led_d = LEDS_OFF;
                end
                default: begin
                    led_d = LEDS_OFF;
                end
            endcase
        end
    end

    assign led    = led_q;
    assign tick_o = tick_q;

endmodule : led_decoder_seq

// File: doc/led_decoder_seq.md
Name: led_decoder_seq

Overview:
- Parametrised successor to the team's registered 3-to-8 LED decoder: an N-to-2^N one-hot decoder with an enable match and active-low registered LED outputs.
- Adds three time-based display modes (chase, blink, off) driven by an internal tick prescaler.
- Sits between the board switch/enable inputs and the LED bank.
- Used for both board self-test and status display.

Parameters:
- SEL_W, 3, width of switch select; OUT_W = 2**SEL_W (localparam, not overridable).
- EN_W, 3, width of enable input.
- EN_MATCH, 3'b100, enable value that activates the block (width EN_W).
- TICK_DIV, 4, clock cycles per display tick (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  EN_W  block active only when enable == EN_MATCH.
- switch  input  SEL_W  selected LED index.
- mode  input  2  0 static, 1 chase, 2 blink, 3 off.
- dir  input  1  chase direction: 0 up, 1 down.
- led  output  OUT_W  registered, active-low (0 = LED lit).
- tick_o  output  1  registered 1-cycle pulse, aligned with each tick-driven led update.

Behaviour:
- Reset: while rst_n=0, state is held as below, asynchronously. Release is synchronous to the next clk edge.
  - led = all ones; tick_o = 0.
  - Prescaler cnt = 0; phase = 0; pos = 0; mode_q = 0.
- en_ok = (enable == EN_MATCH).
- en_ok=0:
  - Next edge: led = all ones, cnt = 0, phase = 0, tick_o = 0.
  - pos holds.
  - mode_q still tracks mode.
- Prescaler (en_ok=1):
  - cnt increments each cycle.
  - At cnt == TICK_DIV-1: cnt wraps to 0 and tick fires (internal, same edge). tick_o = 1 on the following cycle.
- Mode change: if en_ok and mode != mode_q, then on that edge cnt = 0, phase = 0, pos = switch, and no tick occurs. mode_q <= mode every cycle.
- Static (0):
  - led <= ~(1 << switch) every enabled cycle. Latency 1 clk.
  - Prescaler runs; tick_o pulses but does not affect led.
- Chase (1):
  - On entry (mode change edge): pos = switch; led = ~(1 << switch).
  - On each tick: pos = pos+1 (dir=0) or pos-1 (dir=1), modulo OUT_W. Wraps OUT_W-1 -> 0 and 0 -> OUT_W-1.
  - led = ~(1 << new pos) on the same edge.
  - switch is ignored until the next mode entry.
- Blink (2):
  - On each tick: phase toggles.
  - led = phase ? all ones : ~(1 << switch).
  - switch is sampled every cycle, so a switch change is visible within 1 clk while phase = 0.
- Off (3): led = all ones; prescaler runs.
- Simultaneous events, highest priority first:
  1. rst_n
  2. en_ok=0
  3. mode change
  4. tick
- Widths:
  - Shift is OUT_W wide; all OUT_W LEDs are reachable and no invalid index exists.
  - cnt width = $clog2(TICK_DIV).

Decomposition:
- Shared package led_pkg:
  - mode enum: MODE_STATIC = 2'd0, MODE_CHASE = 2'd1, MODE_BLINK = 2'd2, MODE_OFF = 2'd3.
  - LED_ALL_OFF constant helper.
- Sub-module tick_prescaler, with ports clk, rst_n, clr, en, tick; parameter TICK_DIV.
  - Clear is driven by en_ok=0 or mode change.
- Decode and mode FSM stay in the top module.

Test Plan (defaults: SEL_W=3, TICK_DIV=4):
- Reset:
  - rst_n=0 mid-chase with led=8'hFB (pos=2) -> led=8'hFF immediately, without waiting for clk.
  - Release, then static with switch=5 -> led=8'hDF one clk later.
- Enable gating:
  - Static, switch=3, enable=3'b100 -> led=8'hF7.
  - enable=3'b101 -> led=8'hFF next edge and tick_o stays 0.
  - Re-enable -> led=8'hF7.
- Chase up with wrap:
  - mode 0 -> 1 with switch=6, dir=0 -> led=8'hBF.
  - After 4 clks -> 8'h7F.
  - After 8 clks -> 8'hFE (wrap 7 -> 0).
  - tick_o pulses each 4 clks.
- Chase down:
  - Entry with switch=0, dir=1 -> 8'hFE.
  - After 4 clks -> 8'h7F (wrap 0 -> 7).
  - Toggle dir mid-run -> direction reverses at the next tick, pos not reloaded.
- Blink:
  - mode=2, switch=1 -> led 8'hFD for 4 clks, then 8'hFF for 4 clks, repeating.
  - switch changed to 4 during the lit phase -> 8'hEF within 1 clk.
- Simultaneous events:
  - mode change on the same edge as cnt == 3 -> no tick, cnt = 0, pos loads switch.
  - en_ok=0 coinciding with a mode change -> led=8'hFF.
